// File: rtl/inv_meter_pkg.sv
// rtl/inv_meter_pkg.sv - shared types, defaults and helpers for the inverter ring meter
package inv_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        HOLD   = 2'd3
    } meter_state_t;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_WIN_W       = 10;
    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Select-field width; a single channel still needs a one-bit select port.
    function automatic int SEL_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// rtl/ring_edge_sync.sv - ring tap synchroniser, optional majority deglitch, rising-edge pulse
// Optional feature macro: INV_METER_DEGLITCH_EN (3-sample majority filter after the synchroniser).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tap          : asynchronous ring tap
//   edge_pulse   : one-cycle pulse per synchronised rising edge
module ring_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tap,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tap};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef INV_METER_DEGLITCH_EN
    // Majority over the current and two previous synchronised samples; a lone
    // high or low sample can never win the vote, and the vote itself is
    // combinational so the filter costs exactly one cycle of latency.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], synced};
        end
    end

    assign level = (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign level = synced;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_pulse = level & ~prev_q;

endmodule

// File: rtl/inv_ring_meter.sv
// rtl/inv_ring_meter.sv - one-at-a-time inverter ring enable, settle and gated edge counter
// Optional feature macro: INV_METER_DEGLITCH_EN (passed through to ring_edge_sync).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ring_in                  : asynchronous ring taps, one per channel
//   chan_sel, win_len, start : measurement request, sampled when start is accepted in IDLE
//   en_out                   : one-hot ring enable, active in SETTLE and GATE
//   busy                     : high outside IDLE
//   result, overflow         : edge count and saturation flag, qualified by result_valid
//   result_valid/ready       : result handshake, held in HOLD until accepted
//   sel_err                  : one-cycle pulse for an out-of-range chan_sel at start
module inv_ring_meter
    import inv_meter_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ring_in,
    input  logic [SEL_W(N_CH)-1:0]  chan_sel,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    start,
    output logic [N_CH-1:0]         en_out,
    output logic                    busy,
    output logic [CNT_W-1:0]        result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    overflow,
    output logic                    sel_err
);

    localparam int SW = SEL_W(N_CH);

    meter_state_t     state_q, state_d;
    logic [SW-1:0]    sel_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] cyc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             sel_err_q;
    logic [N_CH-1:0]  edge_pulse;
    logic             sel_ok;
    logic             accept;
    logic             settle_done;
    logic             gate_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_tap
        ring_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .rst        (rst),
            .tap        (ring_in[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    assign sel_ok      = int'(chan_sel) < N_CH;
    assign accept      = (state_q == IDLE) && start && sel_ok;
    // cyc_q counts cycles already spent in the current timed state.
    assign settle_done = cyc_q == WIN_W'(SETTLE_CYC - 1);
    assign gate_done   = cyc_q == (win_q - WIN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = (win_q == '0) ? HOLD : GATE;
            GATE:    if (gate_done) state_d = HOLD;
            HOLD:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            win_q     <= '0;
            cyc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= (state_q == IDLE) && start && !sel_ok;
            if (accept) begin
                sel_q <= chan_sel;
                win_q <= win_len;
                cyc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (state_q == SETTLE) begin
                // Edge pulses seen while the ring settles are deliberately dropped.
                cyc_q <= settle_done ? '0 : cyc_q + WIN_W'(1);
            end else if (state_q == GATE) begin
                cyc_q <= cyc_q + WIN_W'(1);
                if (edge_pulse[sel_q]) begin
                    if (cnt_q == '1) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        busy         = state_q != IDLE;
        result_valid = state_q == HOLD;
        result       = cnt_q;
        overflow     = ovf_q;
        sel_err      = sel_err_q;
        en_out       = '0;
        // Reset drops the ring enable combinationally, without waiting for the edge.
        if (!rst && ((state_q == SETTLE) || (state_q == GATE))) begin
            for (int i = 0; i < N_CH; i++) begin
                en_out[i] = sel_q == SW'(i);
            end
        end
    end

endmodule

// File: tb/tb_inv_ring_meter.sv
// tb/tb_inv_ring_meter.sv - directed scoreboard bench for inv_ring_meter
module tb_inv_ring_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ring_in;
    logic [1:0] chan_sel;
    logic [9:0] win_len;
    logic       start;
    logic [3:0] en_out;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overflow;
    logic       sel_err;

    logic [2:0] ring_in3;
    logic [1:0] chan_sel3;
    logic       start3;
    logic [2:0] en_out3;
    logic       busy3;
    logic [7:0] result3;
    logic       result_valid3;
    logic       overflow3;
    logic       sel_err3;

    always #5 clk = ~clk;

    inv_ring_meter #(
        .N_CH (4), .CNT_W (8), .WIN_W (10), .SETTLE_CYC (4), .SYNC_STAGES (2)
    ) u_dut (
        .clk (clk), .rst (rst), .ring_in (ring_in), .chan_sel (chan_sel),
        .win_len (win_len), .start (start), .en_out (en_out), .busy (busy),
        .result (result), .result_valid (result_valid), .result_ready (result_ready),
        .overflow (overflow), .sel_err (sel_err)
    );

    // Three-channel instance: the only way to present an out-of-range select on a 2-bit port.
    inv_ring_meter #(
        .N_CH (3), .CNT_W (8), .WIN_W (10), .SETTLE_CYC (4), .SYNC_STAGES (2)
    ) u_dut3 (
        .clk (clk), .rst (rst), .ring_in (ring_in3), .chan_sel (chan_sel3),
        .win_len (10'd8), .start (start3), .en_out (en_out3), .busy (busy3),
        .result (result3), .result_valid (result_valid3), .result_ready (1'b1),
        .overflow (overflow3), .sel_err (sel_err3)
    );

    typedef struct {
        string tag;
        int    lo;
        int    hi;
        bit    ovf;
        bit    chk_ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic square(input int ch, input int half, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ring_in[ch] = ((i / half) % 2) == 1;
        end
        ring_in[ch] = 1'b0;
    endtask

    task automatic glitches(input int ch, input int lead, input int n, input int gap);
        repeat (lead) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ring_in[ch] = 1'b1;
            @(negedge clk);
            ring_in[ch] = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    // Issues a start, tracks en_out/busy through SETTLE+GATE, then pops the
    // scoreboard entry when result_valid rises and optionally completes the handshake.
    task automatic measure(input int sel, input int win, input int exp_lat, input bit ack);
        int         lat;
        bit         en_ok;
        logic [3:0] en_exp;
        exp_t       e;
        en_exp = 4'b0001 << sel;
        @(negedge clk);
        chan_sel = 2'(sel);
        win_len  = 10'(win);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        en_ok = 1'b1;
        while (result_valid !== 1'b1 && lat < exp_lat + 50) begin
            if (en_out !== en_exp || busy !== 1'b1) en_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("en_busy_window", int'(en_ok), 1);
        chk("hold_en_out", int'(en_out), 0);
        chk("hold_busy", int'(busy), 1);
        if (sb.size() == 0) begin
            chk("sb_entry_present", 0, 1);
        end else begin
            e = sb.pop_front();
            chk_rng({e.tag, "_result"}, int'(result), e.lo, e.hi);
            if (e.chk_ovf) chk({e.tag, "_overflow"}, int'(overflow), int'(e.ovf));
        end
        if (ack) begin
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk("ack_valid_low", int'(result_valid), 0);
            chk("ack_busy_low", int'(busy), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sat_half;
        int   sat_win;
        int   sat_lo;
        bit   sat_chk;
        int   glitch_exp;
        logic [7:0] r0;
        bit   stable;

`ifdef INV_METER_DEGLITCH_EN
        sat_half   = 2;
        sat_win    = 1023;
        sat_lo     = 254;
        sat_chk    = 1'b0;
        glitch_exp = 0;
`else
        sat_half   = 1;
        sat_win    = 600;
        sat_lo     = 255;
        sat_chk    = 1'b1;
        glitch_exp = 8;
`endif

        rst          = 1'b1;
        ring_in      = '0;
        chan_sel     = '0;
        win_len      = '0;
        start        = 1'b0;
        result_ready = 1'b0;
        ring_in3     = '0;
        chan_sel3    = '0;
        start3       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_en_out", int'(en_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_sel_err", int'(sel_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic count: ch2 at a 10-cycle period over a 100-cycle gate.
        fork square(2, 5, 130); join_none
        sb.push_back('{tag: "basic", lo: 9, hi: 11, ovf: 1'b0, chk_ovf: 1'b1});
        measure(2, 100, 104, 1'b1);
        repeat (30) @(negedge clk);

        // Saturation: fastest countable rate on ch0.
        fork square(0, sat_half, sat_win + 80); join_none
        sb.push_back('{tag: "sat", lo: sat_lo, hi: 255, ovf: 1'b1, chk_ovf: sat_chk});
        measure(0, sat_win, 4 + sat_win, 1'b1);
        repeat (90) @(negedge clk);

        // Backpressure: HOLD must survive ignored start pulses.
        fork square(1, 3, 60); join_none
        sb.push_back('{tag: "bp", lo: 2, hi: 4, ovf: 1'b0, chk_ovf: 1'b1});
        measure(1, 20, 24, 1'b0);
        r0     = result;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start    = (i % 2) == 0;
            chan_sel = 2'd2;
            win_len  = 10'd5;
            @(negedge clk);
            if (result !== r0 || result_valid !== 1'b1 || en_out !== 4'b0000) stable = 1'b0;
        end
        start = 1'b0;
        chk("bp_stable", int'(stable), 1);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("bp_release_valid", int'(result_valid), 0);
        chk("bp_release_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("bp_no_queue", int'(busy), 0);
        repeat (40) @(negedge clk);

        // Zero window goes straight from SETTLE to HOLD.
        sb.push_back('{tag: "zero", lo: 0, hi: 0, ovf: 1'b0, chk_ovf: 1'b1});
        measure(3, 0, 4, 1'b1);

        // Bad select on the three-channel instance.
        @(negedge clk);
        chan_sel3 = 2'd3;
        start3    = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("sel_err_pulse", int'(sel_err3), 1);
        chk("sel_err_busy", int'(busy3), 0);
        @(negedge clk);
        chk("sel_err_once", int'(sel_err3), 0);
        chk("sel_err_busy2", int'(busy3), 0);
        chk("sel_err_en", int'(en_out3), 0);
        chk("sel_err_valid", int'(result_valid3), 0);
        chk("sel_err_result", int'(result3), 0);
        chk("sel_err_ovf", int'(overflow3), 0);
        chk("main_sel_err_quiet", int'(sel_err), 0);

        // Reset in the middle of GATE.
        fork square(2, 5, 60); join_none
        @(negedge clk);
        chan_sel = 2'd2;
        win_len  = 10'd50;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_en", int'(en_out), 4);
        rst = 1'b1;
        #1;
        chk("rst_en_immediate", int'(en_out), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_valid", int'(result_valid), 0);
        chk("midrst_overflow", int'(overflow), 0);
        chk("midrst_en", int'(en_out), 0);
        repeat (45) @(negedge clk);

        // Single-cycle glitches on ch1 after the reset.
        fork glitches(1, 12, 8, 4); join_none
        sb.push_back('{tag: "glitch", lo: glitch_exp, hi: glitch_exp, ovf: 1'b0, chk_ovf: 1'b1});
        measure(1, 60, 64, 1'b1);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
